// File: rtl/pmem_burst_adapter_if.sv
// Bundles the cache-side pmem_* line port and the 64-bit burst port of the adapter.
// The slave modport is the adapter; the master modport is its environment (cache plus memory).
interface pmem_burst_adapter_if #(
  parameter int s_line = 256,
  parameter int s_beat = 64
);
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;

  logic [31:0]       burst_address_o;
  logic              burst_read_o;
  logic              burst_write_o;
  logic [s_beat-1:0] burst_wdata_o;
  logic [s_beat-1:0] burst_rdata_i;
  logic              burst_resp_i;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  burst_rdata_i, burst_resp_i,
    output pmem_rdata, pmem_resp,
    output burst_address_o, burst_read_o, burst_write_o, burst_wdata_o
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    output burst_rdata_i, burst_resp_i,
    input  pmem_rdata, pmem_resp,
    input  burst_address_o, burst_read_o, burst_write_o, burst_wdata_o
  );
endinterface

// File: rtl/pmem_burst_adapter.sv
// Converts one cache line read/write into a burst of s_line/s_beat beats on the memory bus.
// All outputs come straight from registers, so they are Moore and drop at once on reset.
module pmem_burst_adapter #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_beat   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  pmem_burst_adapter_if.slave   bus
);

  localparam int BEATS = s_line / s_beat;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [31:0]                   addr_q, addr_d;
  logic [BEATS-1:0][s_beat-1:0]  line_q, line_d;
  logic [BEATS-1:0][s_beat-1:0]  rdata_q, rdata_d;
  logic                          rd_q, rd_d;
  logic                          wr_q, wr_d;
  logic                          resp_q, resp_d;
  logic                          last_beat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    line_d    = line_q;
    rdata_d   = rdata_q;
    last_beat = bus.burst_resp_i && (cnt_q == CNT_W'(BEATS - 1));

    unique case (state_q)
      IDLE: begin
        if (bus.pmem_read) begin
          addr_d  = {bus.pmem_address[31:s_offset], {s_offset{1'b0}}};
          state_d = RD_BURST;
        end else if (bus.pmem_write) begin
          addr_d  = {bus.pmem_address[31:s_offset], {s_offset{1'b0}}};
          line_d  = bus.pmem_wdata;
          state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        if (bus.burst_resp_i) begin
          line_d[cnt_q] = bus.burst_rdata_i;
          cnt_d         = cnt_q + 1'b1;
          // The visible line only changes once a complete line is assembled.
          if (last_beat) begin
            rdata_d = line_d;
            state_d = RD_DONE;
          end
        end
      end
      WR_BURST: begin
        if (bus.burst_resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = WR_DONE;
        end
      end
      RD_DONE, WR_DONE: state_d = IDLE;
      default:          state_d = IDLE;
    endcase

    rd_d   = (state_d == RD_BURST);
    wr_d   = (state_d == WR_BURST);
    resp_d = (state_d == RD_DONE) || (state_d == WR_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.pmem_rdata      = rdata_q;
  assign bus.pmem_resp       = resp_q;
  assign bus.burst_address_o = addr_q;
  assign bus.burst_read_o    = rd_q;
  assign bus.burst_write_o   = wr_q;
  assign bus.burst_wdata_o   = line_q[cnt_q];

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Directed bench for pmem_burst_adapter: inputs change and outputs are sampled on the falling edge.
module tb_pmem_burst_adapter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pmem_burst_adapter_if #(.s_line(256), .s_beat(64)) bus ();

  pmem_burst_adapter #(.s_offset(5), .s_line(256), .s_beat(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] RL1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] RL2 = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                                  64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
  localparam logic [255:0] RL3 = {64'h0F0E_0D0C_0B0A_0908, 64'h0706_0504_0302_0100,
                                  64'hFFEE_DDCC_BBAA_9988, 64'h7766_5544_3322_1100};
  localparam logic [255:0] RL4 = {64'hBBBB_0000_0000_0004, 64'hBBBB_0000_0000_0003,
                                  64'hBBBB_0000_0000_0002, 64'hBBBB_0000_0000_0001};
  localparam logic [255:0] RL5 = {64'hCCCC_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                                  64'hCCCC_0000_0000_0002, 64'hCCCC_0000_0000_0001};
  localparam logic [255:0] RL6 = {64'h5A5A_5A5A_0000_0003, 64'h5A5A_5A5A_0000_0002,
                                  64'h5A5A_5A5A_0000_0001, 64'h5A5A_5A5A_0000_0000};
  localparam logic [255:0] WL1 = {64'hD3D3_3333_D3D3_3333, 64'hD2D2_2222_D2D2_2222,
                                  64'hD1D1_1111_D1D1_1111, 64'hD0D0_0000_D0D0_0000};
  localparam logic [255:0] WL2 = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
                                  64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full zero-wait read; burst_resp_i stays high into the done cycle and must be ignored there.
  task automatic read_line(input string tag, input logic [31:0] a, input logic [31:0] a_exp,
                           input logic [255:0] line);
    bus.pmem_address = a;
    bus.pmem_read    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_rd_active"}, bus.burst_read_o, 1'b1);
      chk({tag, "_no_resp"}, bus.pmem_resp, 1'b0);
      if (i == 0) chk({tag, "_addr"}, bus.burst_address_o, a_exp);
      bus.burst_resp_i  = 1'b1;
      bus.burst_rdata_i = line[i*64 +: 64];
    end
    tick();
    chk({tag, "_resp"}, bus.pmem_resp, 1'b1);
    chk({tag, "_rdata"}, bus.pmem_rdata, line);
    chk({tag, "_rd_dropped"}, bus.burst_read_o, 1'b0);
    tick();
    chk({tag, "_resp_single"}, bus.pmem_resp, 1'b0);
    chk({tag, "_idle_rd"}, bus.burst_read_o, 1'b0);
    bus.pmem_read    = 1'b0;
    bus.burst_resp_i = 1'b0;
  endtask

  // Zero-wait write burst; the write request must already have been accepted at the last edge.
  task automatic write_burst(input string tag, input logic [31:0] a_exp, input logic [255:0] line);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_wr_active"}, bus.burst_write_o, 1'b1);
      chk({tag, "_no_rd"}, bus.burst_read_o, 1'b0);
      chk({tag, "_wdata"}, bus.burst_wdata_o, line[i*64 +: 64]);
      if (i == 0) chk({tag, "_addr"}, bus.burst_address_o, a_exp);
      bus.burst_resp_i = 1'b1;
    end
    tick();
    chk({tag, "_resp"}, bus.pmem_resp, 1'b1);
    chk({tag, "_wr_dropped"}, bus.burst_write_o, 1'b0);
    tick();
    chk({tag, "_resp_single"}, bus.pmem_resp, 1'b0);
    chk({tag, "_idle_wr"}, bus.burst_write_o, 1'b0);
    bus.pmem_write   = 1'b0;
    bus.burst_resp_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] wl;
    int           exp_idx [7];
    logic         resp_pat [7];

    n_cmp = 0;
    n_err = 0;
    rst               = 1'b1;
    bus.pmem_address  = '0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_wdata    = '0;
    bus.burst_rdata_i = '0;
    bus.burst_resp_i  = 1'b0;

    // Reset state
    tick();
    chk("rst_rd", bus.burst_read_o, 1'b0);
    chk("rst_wr", bus.burst_write_o, 1'b0);
    chk("rst_resp", bus.pmem_resp, 1'b0);
    chk("rst_addr", bus.burst_address_o, 32'h0);
    chk("rst_wdata", bus.burst_wdata_o, 64'h0);
    chk("rst_rdata", bus.pmem_rdata, 256'h0);
    tick();
    rst = 1'b0;
    tick();

    // Zero-wait read with unaligned address
    read_line("rd1", 32'h0000_1234, 32'h0000_1220, RL1);
    tick();
    chk("rd1_rdata_hold", bus.pmem_rdata, RL1);

    // Write with gaps on the memory side; cache changes wdata after acceptance
    wl               = WL1;
    exp_idx          = '{0, 1, 1, 2, 3, 3, 3};
    resp_pat         = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bus.pmem_address = 32'hABCD_EF7F;
    bus.pmem_wdata   = wl;
    bus.pmem_write   = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) bus.pmem_wdata = ~wl;
      chk("wr_gap_active", bus.burst_write_o, 1'b1);
      chk("wr_gap_no_resp", bus.pmem_resp, 1'b0);
      chk("wr_gap_wdata", bus.burst_wdata_o, wl[exp_idx[c]*64 +: 64]);
      if (c == 0) chk("wr_gap_addr", bus.burst_address_o, 32'hABCD_EF60);
      bus.burst_resp_i = resp_pat[c];
    end
    tick();
    bus.burst_resp_i = 1'b0;
    chk("wr_gap_resp", bus.pmem_resp, 1'b1);
    chk("wr_gap_wr_dropped", bus.burst_write_o, 1'b0);
    chk("wr_gap_rdata_untouched", bus.pmem_rdata, RL1);
    tick();
    bus.pmem_write = 1'b0;
    chk("wr_gap_resp_single", bus.pmem_resp, 1'b0);
    chk("wr_gap_idle", bus.burst_write_o, 1'b0);
    tick();

    // Simultaneous read and write: read first, write afterwards
    bus.pmem_wdata = WL2;
    bus.pmem_write = 1'b1;
    read_line("both_rd", 32'h0000_0040, 32'h0000_0040, RL2);
    chk("both_no_wr_yet", bus.burst_write_o, 1'b0);
    write_burst("both_wr", 32'h0000_0040, WL2);
    chk("both_rdata_kept", bus.pmem_rdata, RL2);
    tick();

    // Reset in the middle of beat 2 of a read
    bus.pmem_address = 32'h0000_2000;
    bus.pmem_read    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_rd_active", bus.burst_read_o, 1'b1);
      bus.burst_resp_i  = 1'b1;
      bus.burst_rdata_i = RL3[i*64 +: 64];
    end
    #2 rst = 1'b1;
    #1;
    chk("rstmid_rd_async", bus.burst_read_o, 1'b0);
    chk("rstmid_resp", bus.pmem_resp, 1'b0);
    chk("rstmid_addr", bus.burst_address_o, 32'h0);
    chk("rstmid_rdata", bus.pmem_rdata, 256'h0);
    tick();
    rst              = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.burst_resp_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_no_resp", bus.pmem_resp, 1'b0);
      chk("rstmid_idle", bus.burst_read_o, 1'b0);
    end
    read_line("after_rst", 32'h0000_3010, 32'h0000_3000, RL3);
    tick();

    // Back-to-back reads with the request held across the response
    bus.pmem_address = 32'h0000_0100;
    bus.pmem_read    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b1_rd_active", bus.burst_read_o, 1'b1);
      bus.burst_resp_i  = 1'b1;
      bus.burst_rdata_i = RL4[i*64 +: 64];
    end
    tick();
    bus.burst_resp_i = 1'b0;
    chk("b2b1_resp", bus.pmem_resp, 1'b1);
    chk("b2b1_rdata", bus.pmem_rdata, RL4);
    bus.pmem_address = 32'h0000_0200;
    tick();
    chk("b2b_gap_rd", bus.burst_read_o, 1'b0);
    chk("b2b_gap_resp", bus.pmem_resp, 1'b0);
    chk("b2b_gap_rdata", bus.pmem_rdata, RL4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b2_rd_active", bus.burst_read_o, 1'b1);
      chk("b2b2_rdata_hold", bus.pmem_rdata, RL4);
      if (i == 0) chk("b2b2_addr", bus.burst_address_o, 32'h0000_0200);
      bus.burst_resp_i  = 1'b1;
      bus.burst_rdata_i = RL5[i*64 +: 64];
    end
    tick();
    bus.burst_resp_i = 1'b0;
    chk("b2b2_resp", bus.pmem_resp, 1'b1);
    chk("b2b2_rdata", bus.pmem_rdata, RL5);
    tick();
    bus.pmem_read = 1'b0;
    chk("b2b2_resp_single", bus.pmem_resp, 1'b0);
    tick();

    // burst_resp_i pulses while idle must not disturb anything
    bus.burst_resp_i  = 1'b1;
    bus.burst_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_pulse_resp", bus.pmem_resp, 1'b0);
      chk("idle_pulse_rd", bus.burst_read_o, 1'b0);
      chk("idle_pulse_wr", bus.burst_write_o, 1'b0);
    end
    bus.burst_resp_i = 1'b0;
    tick();
    read_line("after_idle_pulse", 32'h0000_4000, 32'h0000_4000, RL6);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pmem_burst_adapter.md
Name: pmem_burst_adapter

Overview:
- Responder on the cache-side pmem_* interface: accepts one 256-bit line read or write from the L2 cache and carries it out as a 4-beat, 64-bit burst on the physical-memory bus.
- Sits between the L2 cache's pmem_* ports and main memory.
- On a read it assembles the four returned beats into one line. On a write it splits the line into four beats.
- Returns exactly one pmem_resp pulse per line transaction.

Parameters:
- s_offset, 5, line offset bits; burst address low s_offset bits are forced to 0.
- s_line, 256, line width in bits.
- s_beat, 64, burst beat width in bits; beats per line = s_line/s_beat = 4. Counter width is log2(beats) = 2.

Ports:
- clk  input  1  clock; rising-edge.
- rst  input  1  asynchronous, active-high reset.
- pmem_address  input  32  line address from cache.
- pmem_read  input  1  line read request; held by cache until pmem_resp.
- pmem_write  input  1  line write request; held by cache until pmem_resp.
- pmem_wdata  input  s_line  line to write; valid while pmem_write.
- pmem_rdata  output  s_line  assembled read line; valid when pmem_resp is high.
- pmem_resp  output  1  one-cycle completion pulse.
- burst_address_o  output  32  line-aligned burst address.
- burst_read_o  output  1  burst read request.
- burst_write_o  output  1  burst write request.
- burst_wdata_o  output  s_beat  current write beat.
- burst_rdata_i  input  s_beat  read beat from memory.
- burst_resp_i  input  1  memory beat acknowledge; one beat transferred per high cycle.

Behaviour:
- Reset (asynchronous, active-high rst):
  - All outputs 0, pmem_rdata 0.
  - State IDLE, beat counter 0, line buffer and address register 0.
- Outputs are Moore: a function of registered state and registers only.
- FSM states: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - pmem_read=1: latch {pmem_address[31:s_offset], s_offset'b0} into the address register, go to RD_BURST.
  - Else pmem_write=1: latch the address the same way, latch pmem_wdata into the line buffer, go to WR_BURST.
  - Read wins if both are high. The write stays pending and is taken on a later IDLE cycle.
  - burst_resp_i is ignored in IDLE.
- RD_BURST:
  - burst_read_o=1; burst_address_o = latched address.
  - Each cycle with burst_resp_i=1: line[cnt*64 +: 64] <= burst_rdata_i, and cnt increments. Beat 0 fills bits [63:0].
  - Gaps (burst_resp_i=0) are allowed; the counter holds.
  - On the beat with cnt==3: cnt wraps to 0 and the FSM goes to RD_DONE.
- RD_DONE:
  - pmem_resp=1 for exactly this one cycle; pmem_rdata = assembled line; burst_read_o=0.
  - Next state is always IDLE, and requests are not sampled in this cycle.
  - pmem_rdata holds its value until the next read line completes.
- WR_BURST:
  - burst_write_o=1; burst_address_o = latched address; burst_wdata_o = buffer[cnt*64 +: 64].
  - Advance on burst_resp_i exactly as in RD_BURST. On cnt==3 with resp, go to WR_DONE.
  - pmem_wdata changes after acceptance have no effect.
- WR_DONE: pmem_resp=1 for one cycle, burst_write_o=0, then IDLE.
- Latency with zero-wait memory:
  - Request seen in IDLE at edge k.
  - Burst active in cycles k+1..k+4.
  - pmem_resp high in cycle k+5.
  - Next request accepted no earlier than edge k+6.
- Cache contract: the cache drops pmem_read/pmem_write in the cycle after pmem_resp. The adapter is back in IDLE then, so a request still held would start a new transaction.
- Reset mid-burst:
  - Abort immediately; burst_read_o/burst_write_o drop asynchronously.
  - The partial line is discarded, cnt returns to 0, and no pmem_resp is issued.
- burst_resp_i held high continuously transfers one beat per cycle. A fifth consecutive high after the last beat lands in *_DONE and is ignored.

Test Plan:
- Read, zero-wait: pmem_address=0x0000_1234, pmem_read=1; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  -> burst_address_o=0x0000_1220 and burst_read_o high for 4 cycles.
  -> pmem_resp single pulse 5 cycles after request, pmem_rdata={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write with gaps: pmem_wdata = {D3,D2,D1,D0}, memory asserts burst_resp_i on cycles 1,3,4,7.
  -> burst_wdata_o shows D0 until the first resp, then D1, D2, D3.
  -> pmem_resp one cycle after the 4th resp.
- Simultaneous pmem_read and pmem_write in IDLE -> read burst performed first, then the write burst, each with its own pmem_resp.
- Reset asserted during beat 2 of a read -> outputs 0 immediately, no pmem_resp. A following read completes normally with correct beat order (cnt restarted at 0).
- Back-to-back reads at addresses 0x100 then 0x200 -> second burst_read_o starts no earlier than the cycle after the first pmem_resp, and the first pmem_rdata holds until the second pmem_resp.
- burst_resp_i pulsed while idle -> no state change, no pmem_resp.
